// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and elaboration helpers for the line-buffer chain controller.
package line_buf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_WRAP,
    ST_DONE
  } state_e;

  // Counter width wide enough for the larger image dimension (minimum 1 bit).
  function automatic int cnt_w(input int img_w, input int img_h);
    int m;
    m = (img_w > img_h) ? img_w : img_h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic bit geom_ok(input int k, input int img_w, input int fifo_size);
    return (k >= 2) && (k <= img_w) && (img_w <= fifo_size);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel handshake, FIFO-chain strobes and window report of line_buf_ctrl.
interface line_buf_ctrl_if #(
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic             fifo_wr_clr;
  logic             fifo_rd_clr;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic             fifo_wr_inc;
  logic             fifo_rd_inc;
  logic             win_valid;
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;

  modport master (
    output in_valid,
    input  in_ready, fifo_wr_clr, fifo_rd_clr, fifo_wr_en, fifo_rd_en,
    input  fifo_wr_inc, fifo_rd_inc, win_valid, win_row, win_col
  );

  modport slave (
    input  in_valid,
    output in_ready, fifo_wr_clr, fifo_rd_clr, fifo_wr_en, fifo_rd_en,
    output fifo_wr_inc, fifo_rd_inc, win_valid, win_row, win_col
  );
endinterface

// File: rtl/lb_pos_counter.sv
// Column/row position of the next pixel to be accepted, with row-end and frame-end flags.
module lb_pos_counter #(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_row_end,
  output logic             o_frame_end
);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_row_end   = (r_col == COL_LAST);
  assign o_frame_end = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/line_buf_ctrl.sv
// Frame sequencer for the K-1 lockstep line-buffer FIFOs of the conv front end.
// Optional LBCTRL_PERF_EN adds o_stall_cnt (RUN cycles with no valid pixel).
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int IMG_W     = 416,
  parameter int IMG_H     = 416,
  parameter int K         = 3,
  parameter int FIFO_SIZE = 4608
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  line_buf_ctrl_if.slave bus,
  output logic          o_busy,
  output logic          o_done
`ifdef LBCTRL_PERF_EN
  ,
  output logic [31:0]   o_stall_cnt
`endif
);
  localparam int CNT_W = cnt_w(IMG_W, IMG_H);
  localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(K - 1);

  if (!geom_ok(K, IMG_W, FIFO_SIZE)) begin : g_bad_geom
    $error("line_buf_ctrl: K/IMG_W/FIFO_SIZE combination is illegal");
  end

  state_e           r_state;
  logic             r_in_ready;
  logic             r_clr;
  logic             r_busy;
  logic             r_done;
  logic             r_win_valid;
  logic [CNT_W-1:0] r_win_row;
  logic [CNT_W-1:0] r_win_col;

  logic             w_accept;
  logic             w_abort;
  logic             w_win_hit;
  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic             w_row_end;
  logic             w_frame_end;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_abort   = i_abort & (r_state != ST_IDLE);
  assign w_win_hit = w_accept && (w_row >= WIN_MIN) && (w_col >= WIN_MIN);

  lb_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       ((r_state == ST_CLEAR) | w_abort),
    .i_inc       (w_accept),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_row_end   (w_row_end),
    .o_frame_end (w_frame_end)
  );

  // Outputs are registered alongside the next state so each state's strobes
  // are glitch-free; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_clr      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
        r_clr      <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: if (i_start && !i_abort) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
          end
          ST_CLEAR, ST_WRAP: begin
            r_state    <= ST_RUN;
            r_in_ready <= 1'b1;
          end
          ST_RUN: if (w_accept && w_frame_end) begin
            r_state    <= ST_DONE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_accept && w_row_end) begin
            r_state    <= ST_WRAP;
            r_in_ready <= 1'b0;
            r_clr      <= 1'b1;
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Window flag lines up with the FIFO read data, one cycle after the accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_win_valid <= w_win_hit;
      if (w_win_hit) begin
        r_win_row <= w_row;
        r_win_col <= w_col;
      end
    end
  end

`ifdef LBCTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_IDLE && i_start && !i_abort) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_RUN && !bus.in_valid && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign bus.in_ready    = r_in_ready;
  assign bus.fifo_wr_clr = r_clr;
  assign bus.fifo_rd_clr = r_clr;
  assign bus.fifo_wr_en  = w_accept;
  assign bus.fifo_rd_en  = w_accept;
  assign bus.fifo_wr_inc = w_accept;
  assign bus.fifo_rd_inc = w_accept;
  assign bus.win_valid   = r_win_valid;
  assign bus.win_row     = r_win_row;
  assign bus.win_col     = r_win_col;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl: frame-level model plus directed literal checks.
module tb_line_buf_ctrl;
  localparam int MW = 4;
  localparam int MH = 3;
  localparam int MK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, start2;
  logic busy, done, busy2, done2;
`ifdef LBCTRL_PERF_EN
  logic [31:0] stall, stall2;
`endif

  line_buf_ctrl_if #(.CNT_W(2)) bus  ();
  line_buf_ctrl_if #(.CNT_W(2)) bus2 ();

  line_buf_ctrl #(.IMG_W(MW), .IMG_H(MH), .K(MK), .FIFO_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .bus(bus),
    .o_busy(busy), .o_done(done)
`ifdef LBCTRL_PERF_EN
    , .o_stall_cnt(stall)
`endif
  );

  line_buf_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .FIFO_SIZE(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_abort(1'b0), .bus(bus2),
    .o_busy(busy2), .o_done(done2)
`ifdef LBCTRL_PERF_EN
    , .o_stall_cnt(stall2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Frame-level model: tracks pixels accepted and the one-cycle non-ready slots.
  bit          m_active, m_gap, m_clr, m_done, m_wv;
  int          m_pix;
  logic [1:0]  m_wr, m_wc;
  int unsigned m_stall;

  function automatic bit m_ready();
    return m_active && !m_gap;
  endfunction

  task automatic model_step();
    bit acc, was_done;
    int r, c;
    if (!rst_n) begin
      {m_active, m_gap, m_clr, m_done, m_wv} = '0;
      m_pix = 0; m_wr = '0; m_wc = '0; m_stall = 0;
      return;
    end
    acc = m_ready() && bus.in_valid;
    r = m_pix / MW;
    c = m_pix % MW;
    m_wv = acc && (r >= MK - 1) && (c >= MK - 1);
    if (m_wv) begin
      m_wr = 2'(r);
      m_wc = 2'(c);
    end
    if (m_ready() && !bus.in_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
    was_done = m_done;
    m_clr  = 1'b0;
    m_done = 1'b0;
    if (m_active && abort) begin
      m_active = 1'b0; m_gap = 1'b0; m_clr = 1'b1;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1'b1; m_gap = 1'b1; m_clr = 1'b1; m_pix = 0; m_stall = 0;
      end
    end else if (was_done) begin
      m_active = 1'b0; m_gap = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (acc) begin
      m_pix++;
      if (m_pix == MW * MH) begin
        m_gap = 1'b1; m_done = 1'b1;
      end else if (m_pix % MW == 0) begin
        m_gap = 1'b1; m_clr = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process and event recorder, both on the falling edge.
  bit         cmp_en = 1'b0;
  bit         rec_on = 1'b0;
  int         rec_cyc, n_wr, cyc;
  int         clr_q[$];
  int         done_q[$];
  logic [3:0] win_q[$];
  int         w2_cyc[$];
  logic [3:0] w2_pos[$];
  int         d2_cyc[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (cmp_en) begin
      check("in_ready", bus.in_ready, m_ready());
      check("strobes", {bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_inc, bus.fifo_rd_inc},
            {4{m_ready() && bus.in_valid}});
      check("clr", {bus.fifo_wr_clr, bus.fifo_rd_clr}, {2{m_clr}});
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("win_valid", bus.win_valid, m_wv);
      check("win_pos", {bus.win_row, bus.win_col}, {m_wr, m_wc});
`ifdef LBCTRL_PERF_EN
      check("stall_cnt", stall, m_stall);
`endif
    end
    if (rec_on) begin
      if (bus.fifo_wr_clr) clr_q.push_back(rec_cyc);
      if (bus.fifo_wr_en) n_wr++;
      if (done) done_q.push_back(rec_cyc);
      if (bus.win_valid) win_q.push_back({bus.win_row, bus.win_col});
      rec_cyc++;
    end
    if (bus2.win_valid) begin
      w2_cyc.push_back(cyc);
      w2_pos.push_back({bus2.win_row, bus2.win_col});
    end
    if (done2) d2_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start from IDLE; on return the bench is in the CLEAR cycle (cycle 0).
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    clr_q.delete(); done_q.delete(); win_q.delete();
    n_wr = 0; rec_cyc = 0; rec_on = 1'b1;
  endtask

  // pat 0: in_valid always high, 1: high on even cycles, 2: low.
  task automatic run_cycles(input int n, input int pat, input int start_hold);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = (pat == 0) || (pat == 1 && i % 2 == 0);
      start = (i < start_hold);
      tick();
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input bit cont);
    check({tag, "_wr_cnt"}, n_wr, 12);
    check({tag, "_done_cnt"}, done_q.size(), 1);
    check({tag, "_win_cnt"}, win_q.size(), 2);
    if (win_q.size() == 2) begin
      check({tag, "_win0"}, win_q[0], 4'hA);
      check({tag, "_win1"}, win_q[1], 4'hB);
    end
    if (cont) begin
      check({tag, "_clr_cnt"}, clr_q.size(), 3);
      if (clr_q.size() == 3) begin
        check({tag, "_clr0"}, clr_q[0], 0);
        check({tag, "_clr1"}, clr_q[1], 5);
        check({tag, "_clr2"}, clr_q[2], 10);
      end
      if (done_q.size() == 1) check({tag, "_done_cyc"}, done_q[0], 15);
    end
  endtask

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {busy, done, bus.in_ready, bus.win_valid, bus.win_row, bus.win_col}, 0);
    tick();

    // Continuous stream, 12 pixels.
    launch();
    run_cycles(20, 0, 0);
    rec_on = 1'b0;
    check_frame("cont", 1'b1);

    // Alternating valid.
    launch();
    run_cycles(34, 1, 0);
    rec_on = 1'b0;
    check_frame("toggle", 1'b0);
`ifdef LBCTRL_PERF_EN
    check("toggle_stall", stall, 10);
`endif

    // Abort after the sixth pixel.
    launch();
    bus.in_valid = 1'b1;
    g = 0;
    while (n_wr < 6 && g < 50) begin tick(); g++; end
    if (g >= 50) fail_now("abort_wait");
    bus.in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_clr", {bus.fifo_wr_clr, bus.fifo_rd_clr}, 2'b11);
    check("abort_busy", busy, 1'b0);
    tick();
    run_cycles(6, 2, 0);
    rec_on = 1'b0;
    check("abort_no_done", done_q.size(), 0);
    check("abort_wr_cnt", n_wr, 6);
    launch();
    run_cycles(20, 0, 0);
    rec_on = 1'b0;
    check_frame("abort_restart", 1'b1);

    // Reset asserted during the first WRAP.
    launch();
    bus.in_valid = 1'b1;
    g = 0;
    while (n_wr < 4 && g < 50) begin tick(); g++; end
    if (g >= 50) fail_now("wrap_wait");
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_outputs", {busy, done, bus.in_ready, bus.fifo_wr_clr, bus.fifo_rd_clr,
          bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_inc, bus.fifo_rd_inc,
          bus.win_valid, bus.win_row, bus.win_col}, 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rec_on = 1'b0;
    launch();
    run_cycles(20, 0, 0);
    rec_on = 1'b0;
    check_frame("post_reset", 1'b1);

    // start held through RUN, then start together with abort in IDLE.
    launch();
    run_cycles(20, 0, 9);
    rec_on = 1'b0;
    check_frame("start_held", 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_clr", bus.fifo_wr_clr, 1'b0);
    tick();

    // 3x3 image with 3x3 kernel: single window in the DONE cycle.
    bus2.in_valid = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    bus2.in_valid = 1'b0;
    check("k3_win_cnt", w2_pos.size(), 1);
    check("k3_done_cnt", d2_cyc.size(), 1);
    if (w2_pos.size() == 1 && d2_cyc.size() == 1) begin
      check("k3_win_pos", w2_pos[0], 4'hA);
      check("k3_win_in_done", w2_cyc[0], d2_cyc[0]);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
